// File: rtl/ifm_sparse_chunk_nbank_buf.sv
// ifm_sparse_chunk_nbank_buf: N-bank sparse-chunk IFM buffer shared by several compute units; IFM_RD_PIPE_EN registers the read outputs
module ifm_sparse_chunk_nbank_buf #(
  parameter int MEM_SIZE         = 128,
  parameter int BUS_SIZE         = 32,
  parameter int PREFIX_SUM_SIZE  = 8,
  parameter int COMPUTE_UNIT_NUM = 4,
  parameter int BANK_NUM         = 3
) (
  input  logic                                                         clk_i,
  input  logic                                                         rst_i,
  input  logic                                                         wr_valid_i,
  output logic                                                         wr_ready_o,
  input  logic [BUS_SIZE-1:0]                                          wr_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]                                        wr_nonzero_data_i,
  input  logic                                                         chunk_start_i,
  output logic                                                         rd_avail_o,
  output logic [COMPUTE_UNIT_NUM-1:0]                                  cu_active_o,
  input  logic [COMPUTE_UNIT_NUM*$clog2(PREFIX_SUM_SIZE)-1:0]          shift_i,
  input  logic [COMPUTE_UNIT_NUM-1:0]                                  pri_enc_last_i,
  input  logic [COMPUTE_UNIT_NUM*$clog2(MEM_SIZE/PREFIX_SUM_SIZE)-1:0] rd_sparsemap_addr_i,
  output logic [COMPUTE_UNIT_NUM*PREFIX_SUM_SIZE-1:0]                  rd_sparsemap_o,
  input  logic [COMPUTE_UNIT_NUM*($clog2(MEM_SIZE)+1)-1:0]             rd_addr_i,
  output logic [COMPUTE_UNIT_NUM*8-1:0]                                rd_data_o
);
  localparam int BEATS   = MEM_SIZE / BUS_SIZE;
  localparam int WIN_NUM = MEM_SIZE / PREFIX_SUM_SIZE;
  localparam int P       = PREFIX_SUM_SIZE;
  localparam int W2      = 2 * P;
  localparam int CU      = COMPUTE_UNIT_NUM;
  localparam int SW      = $clog2(P);
  localparam int KW      = $clog2(WIN_NUM);
  localparam int AW      = $clog2(MEM_SIZE) + 1;
  localparam int BW      = $clog2(BANK_NUM);
  localparam int CW      = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {FREE, FILL, FULL, READ} bank_st_t;
  bank_st_t st [BANK_NUM];
  logic [BW-1:0] wr_ptr, rd_ptr, rd_bank;
  logic [CW-1:0] beat;
  logic [CU-1:0] rel_mask, rel;
  logic [MEM_SIZE-1:0] sm [BANK_NUM];
  logic [MEM_SIZE*8-1:0] dat [BANK_NUM];
  logic wr_fire, start, last_beat;
  assign wr_ready_o = st[wr_ptr] == FREE || st[wr_ptr] == FILL;
  assign rd_avail_o = st[rd_ptr] == FULL && cu_active_o == '0;
  assign wr_fire    = wr_valid_i && wr_ready_o;
  assign start      = chunk_start_i && rd_avail_o;
  assign last_beat  = beat == CW'(BEATS - 1);
  // bank payload storage; stale contents of a discarded bank are never visible because no CU binds to it
  always_ff @(posedge clk_i)
    if (wr_fire)
      for (int c = 0; c < BEATS; c++)
        if (beat == CW'(c)) begin
          sm[wr_ptr][c*BUS_SIZE +: BUS_SIZE] <= wr_sparsemap_i;
          dat[wr_ptr][c*BUS_SIZE*8 +: BUS_SIZE*8] <= wr_nonzero_data_i;
        end
  // bank lifecycle, write/read pointers and CU binding; write, start and free always target different banks
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      for (int b = 0; b < BANK_NUM; b++) st[b] <= FREE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_bank <= '0;
      beat <= '0;
      cu_active_o <= '0;
      rel_mask <= '0;
    end else begin
      if (wr_fire) begin
        st[wr_ptr] <= last_beat ? FULL : FILL;
        beat <= last_beat ? '0 : beat + 1'b1;
        if (last_beat) wr_ptr <= wr_ptr == BW'(BANK_NUM - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (start) begin
        st[rd_ptr] <= READ;
        rd_bank <= rd_ptr;
        cu_active_o <= '1;
        rel_mask <= '0;
        rd_ptr <= rd_ptr == BW'(BANK_NUM - 1) ? '0 : rd_ptr + 1'b1;
      end else if (|rel) begin
        cu_active_o <= cu_active_o & ~rel;
        rel_mask <= rel_mask | rel;
        if (&(rel_mask | rel)) st[rd_bank] <= FREE;
      end
    end
  for (genvar g = 0; g < CU; g++) begin : g_cu
    logic [KW-1:0] k;
    logic [SW-1:0] sh;
    logic [AW-1:0] a;
    logic [W2-1:0] win;
    logic [P-1:0] sm_v;
    logic [7:0] d_v;
    assign k  = rd_sparsemap_addr_i[g*KW +: KW];
    assign sh = shift_i[g*SW +: SW];
    assign a  = rd_addr_i[g*AW +: AW];
    assign rel[g] = cu_active_o[g] && k == KW'(WIN_NUM - 1) && pri_enc_last_i[g];
    // two adjacent granules (zero above the bank top) shifted right; data address is 1-based
    always_comb begin
      win  = W2'({{P{1'b0}}, sm[rd_bank]} >> (k * P));
      sm_v = cu_active_o[g] ? P'(win >> sh) : '0;
      d_v  = (cu_active_o[g] && a != '0 && a <= AW'(MEM_SIZE)) ? 8'(dat[rd_bank] >> ((a - 1'b1) * 8)) : '0;
    end
`ifdef IFM_RD_PIPE_EN
    logic [P-1:0] sm_q;
    logic [7:0] d_q;
    // one-cycle registered read path
    always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
        sm_q <= '0;
        d_q <= '0;
      end else begin
        sm_q <= sm_v;
        d_q <= d_v;
      end
    assign rd_sparsemap_o[g*P +: P] = sm_q;
    assign rd_data_o[g*8 +: 8]      = d_q;
`else
    assign rd_sparsemap_o[g*P +: P] = sm_v;
    assign rd_data_o[g*8 +: 8]      = d_v;
`endif
  end
endmodule

// File: tb/tb_ifm_sparse_chunk_nbank_buf.sv
// tb_ifm_sparse_chunk_nbank_buf: directed and random checks against a queue-based bank model
module tb_ifm_sparse_chunk_nbank_buf;
  localparam int MEM = 128, BUS = 32, P = 8, CU = 4, NB = 3;
  localparam int BEATS = MEM / BUS, WIN = MEM / P, SW = 3, KW = 4, AW = 8;
  logic clk_i = 0, rst_i = 0;
  logic wr_valid_i = 0, wr_ready_o;
  logic [BUS-1:0] wr_sparsemap_i = '0;
  logic [BUS*8-1:0] wr_nonzero_data_i = '0;
  logic chunk_start_i = 0, rd_avail_o;
  logic [CU-1:0] cu_active_o, pri_enc_last_i = '0;
  logic [CU*SW-1:0] shift_i = '0;
  logic [CU*KW-1:0] rd_sparsemap_addr_i = '0;
  logic [CU*P-1:0] rd_sparsemap_o;
  logic [CU*AW-1:0] rd_addr_i = '0;
  logic [CU*8-1:0] rd_data_o;
  ifm_sparse_chunk_nbank_buf dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_sparsemap_i(wr_sparsemap_i), .wr_nonzero_data_i(wr_nonzero_data_i),
    .chunk_start_i(chunk_start_i), .rd_avail_o(rd_avail_o), .cu_active_o(cu_active_o),
    .shift_i(shift_i), .pri_enc_last_i(pri_enc_last_i), .rd_sparsemap_addr_i(rd_sparsemap_addr_i),
    .rd_sparsemap_o(rd_sparsemap_o), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
  );
  always #5 clk_i = ~clk_i;
  int checks = 0, errors = 0;
  bit m_sm [NB][MEM];
  logic [7:0] m_dat [NB][MEM];
  int full_q[$];
  int wb, beat, reading;
  logic [CU-1:0] m_act;
  logic [P-1:0] prev_sm [CU];
  logic [7:0] prev_d [CU];
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic m_ready();
    foreach (full_q[i]) if (full_q[i] == wb) return 1'b0;
    return wb != reading;
  endfunction
  function automatic logic m_avail();
    return full_q.size() > 0 && m_act == '0;
  endfunction
  function automatic logic [P-1:0] exp_sm(int n);
    int k = int'(rd_sparsemap_addr_i[n*KW +: KW]);
    int s = int'(shift_i[n*SW +: SW]);
    logic [P-1:0] r = '0;
    if (!m_act[n]) return '0;
    for (int i = 0; i < P; i++) if (k*P + i + s < MEM) r[i] = m_sm[reading][k*P + i + s];
    return r;
  endfunction
  function automatic logic [7:0] exp_d(int n);
    int a = int'(rd_addr_i[n*AW +: AW]);
    if (!m_act[n] || a == 0 || a > MEM) return '0;
    return m_dat[reading][a-1];
  endfunction
  task automatic model_reset();
    full_q.delete();
    wb = 0;
    beat = 0;
    reading = -1;
    m_act = '0;
    for (int n = 0; n < CU; n++) begin
      prev_sm[n] = '0;
      prev_d[n] = '0;
    end
  endtask
  task automatic cycle();
    logic wf, st;
    logic [CU-1:0] rel;
    @(negedge clk_i);
    check("wr_ready", wr_ready_o, m_ready());
    check("rd_avail", rd_avail_o, m_avail());
    check("cu_active", cu_active_o, m_act);
    for (int n = 0; n < CU; n++) begin
`ifdef IFM_RD_PIPE_EN
      check($sformatf("rd_sm%0d", n), rd_sparsemap_o[n*P +: P], prev_sm[n]);
      check($sformatf("rd_data%0d", n), rd_data_o[n*8 +: 8], prev_d[n]);
`else
      check($sformatf("rd_sm%0d", n), rd_sparsemap_o[n*P +: P], exp_sm(n));
      check($sformatf("rd_data%0d", n), rd_data_o[n*8 +: 8], exp_d(n));
`endif
      prev_sm[n] = exp_sm(n);
      prev_d[n] = exp_d(n);
      rel[n] = m_act[n] && rd_sparsemap_addr_i[n*KW +: KW] == KW'(WIN-1) && pri_enc_last_i[n];
    end
    wf = wr_valid_i && m_ready();
    st = chunk_start_i && m_avail();
    @(posedge clk_i);
    if (st) begin
      reading = full_q.pop_front();
      m_act = '1;
    end else if (rel != '0) begin
      m_act = m_act & ~rel;
      if (m_act == '0) reading = -1;
    end
    if (wf) begin
      for (int j = 0; j < BUS; j++) begin
        m_sm[wb][beat*BUS + j] = wr_sparsemap_i[j];
        m_dat[wb][beat*BUS + j] = wr_nonzero_data_i[j*8 +: 8];
      end
      beat++;
      if (beat == BEATS) begin
        full_q.push_back(wb);
        wb = (wb + 1) % NB;
        beat = 0;
      end
    end
    #1;
  endtask
  task automatic do_reset();
    rst_i = 0;
    #2;
    check("rst_wr_ready", wr_ready_o, 1);
    check("rst_rd_avail", rd_avail_o, 0);
    check("rst_cu_active", cu_active_o, 0);
    check("rst_rd_sm", rd_sparsemap_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    model_reset();
    #1 rst_i = 1;
  endtask
  task automatic set_rel(logic [CU-1:0] m);
    for (int n = 0; n < CU; n++) rd_sparsemap_addr_i[n*KW +: KW] = m[n] ? KW'(WIN-1) : '0;
    pri_enc_last_i = m;
  endtask
  task automatic rand_beat();
    wr_sparsemap_i = $urandom;
    for (int i = 0; i < BUS*8/32; i++) wr_nonzero_data_i[i*32 +: 32] = $urandom;
  endtask
  task automatic fill(int n);
    wr_valid_i = 1;
    for (int i = 0; i < n; i++) begin
      rand_beat();
      cycle();
    end
    wr_valid_i = 0;
  endtask
  task automatic rand_in();
    wr_valid_i = $urandom_range(0, 9) < 7;
    rand_beat();
    chunk_start_i = $urandom_range(0, 3) == 0;
    for (int n = 0; n < CU; n++) begin
      rd_sparsemap_addr_i[n*KW +: KW] = $urandom_range(0, 3) == 0 ? KW'(WIN-1) : KW'($urandom_range(0, WIN-1));
      shift_i[n*SW +: SW] = SW'($urandom_range(0, P-1));
      pri_enc_last_i[n] = 1'($urandom_range(0, 1));
      rd_addr_i[n*AW +: AW] = AW'($urandom_range(0, MEM + 20));
    end
  endtask
  initial begin
    model_reset();
    @(posedge clk_i);
    #1;
    do_reset();
    chunk_start_i = 1;
    cycle();
    chunk_start_i = 0;
    check("t5_no_full_start", cu_active_o, 0);
    wr_valid_i = 1;
    for (int c = 0; c < BEATS; c++) begin
      wr_sparsemap_i = 32'h0000_00FF << c;
      for (int j = 0; j < BUS; j++) wr_nonzero_data_i[j*8 +: 8] = 8'(c*BUS + j + 1);
      cycle();
    end
    wr_valid_i = 0;
    check("t1_avail", rd_avail_o, 1);
    check("t1_ready_bank1", wr_ready_o, 1);
    chunk_start_i = 1;
    rd_addr_i[0 +: AW] = 1;
    cycle();
    chunk_start_i = 0;
    cycle();
    check("t2_sm", rd_sparsemap_o[0 +: P], 8'hFF);
    check("t2_data", rd_data_o[0 +: 8], 8'h01);
    rd_addr_i[0 +: AW] = 0;
    cycle();
    cycle();
    check("t2_addr0", rd_data_o[0 +: 8], 0);
    set_rel('1);
    cycle();
    set_rel('0);
    wr_valid_i = 1;
    for (int c = 0; c < BEATS; c++) begin
      wr_sparsemap_i = c == 0 ? 32'h0000_A53C : c == BEATS-1 ? 32'hFF00_0000 : 32'h0;
      cycle();
    end
    wr_valid_i = 0;
    chunk_start_i = 1;
    shift_i[0 +: SW] = 4;
    shift_i[SW +: SW] = 4;
    rd_sparsemap_addr_i[KW +: KW] = KW'(WIN-1);
    cycle();
    cycle();
    chunk_start_i = 0;
    check("t5_active_hold", cu_active_o, 4'hF);
    check("t3_shift", rd_sparsemap_o[0 +: P], 8'h53);
    check("t3_top_win", rd_sparsemap_o[P +: P], 8'h0F);
    fill(2*BEATS + 2);
    check("t4_backpressure", wr_ready_o, 0);
    for (int n = 0; n < CU; n++) begin
      set_rel(CU'(1) << n);
      cycle();
      set_rel('0);
      check($sformatf("t4_ready_after_cu%0d", n), wr_ready_o, n == CU-1);
      cycle();
    end
    fill(2);
    do_reset();
    check("t6_active", cu_active_o, 0);
    fill(BEATS);
    check("t6_avail", rd_avail_o, 1);
    chunk_start_i = 1;
    rd_addr_i[0 +: AW] = 1;
    cycle();
    chunk_start_i = 0;
    cycle();
    check("t6_bank0", rd_data_o[0 +: 8], m_dat[0][0]);
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      if (i == 1500) do_reset();
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
